// File: rtl/rf_wr_arbiter_pkg.sv
// Shared CPU definitions used by the register-file write arbiter: widths, register
// count and the requester index type.
package rf_wr_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    typedef enum logic {
        REQ_WB = 1'b0,
        REQ_MC = 1'b1
    } req_idx_t;

    // Pointing at the multi-cycle unit after reset lets writeback win the first tie.
    localparam req_idx_t PTR_RESET = REQ_MC;

    function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
        reg_mask_t one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a multi-cycle unit.
// Optional pending-write scoreboard enabled by defining RF_WR_SCOREBOARD_EN.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic      clk_i,
    input  logic      reset_n_i,
`ifdef RF_WR_SCOREBOARD_EN
    input  logic      issue_i,
    input  reg_addr_t issue_rd_i,
    output reg_mask_t busy_o,
`endif
    input  logic      wb_valid_i,
    input  reg_addr_t wb_wr_i,
    input  reg_data_t wb_wd_i,
    output logic      wb_ready_o,
    input  logic      mc_valid_i,
    input  reg_addr_t mc_wr_i,
    input  reg_data_t mc_wd_i,
    output logic      mc_ready_o,
    output logic      rf_we_o,
    output reg_addr_t rf_wr_o,
    output reg_data_t rf_wd_o
);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    req_idx_t        last_gnt;
    req_idx_t        gnt_idx;
    logic            any_gnt;
    reg_addr_t       sel_wr;
    reg_data_t       sel_wd;

    assign req = {mc_valid_i, wb_valid_i};

    rr_arb2 u_arb (
        .req (req),
        .ptr (last_gnt),
        .gnt (gnt)
    );

    assign wb_ready_o = gnt[REQ_WB];
    assign mc_ready_o = gnt[REQ_MC];
    assign any_gnt    = |gnt;
    assign gnt_idx    = gnt[REQ_MC] ? REQ_MC : REQ_WB;
    assign sel_wr     = (gnt_idx == REQ_MC) ? mc_wr_i : wb_wr_i;
    assign sel_wd     = (gnt_idx == REQ_MC) ? mc_wd_i : wb_wd_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_gnt <= PTR_RESET;
        end else if (any_gnt) begin
            last_gnt <= gnt_idx;
        end
    end

    // Register 0 is hardwired, so its writes are accepted but never strobed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rf_we_o <= 1'b0;
            rf_wr_o <= '0;
            rf_wd_o <= '0;
        end else if (any_gnt) begin
            rf_we_o <= (sel_wr != '0);
            rf_wr_o <= sel_wr;
            rf_wd_o <= sel_wd;
        end else begin
            rf_we_o <= 1'b0;
        end
    end

`ifdef RF_WR_SCOREBOARD_EN
    reg_mask_t busy_q;
    reg_mask_t set_mask;
    reg_mask_t clr_mask;
    reg_mask_t busy_next;

    // A new issue outranks a retiring write to the same register.
    always_comb begin
        set_mask     = issue_i ? reg_onehot(issue_rd_i) : '0;
        clr_mask     = any_gnt ? reg_onehot(sel_wr) : '0;
        busy_next    = (busy_q & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_o = busy_q;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized and directed bench for rf_wr_arbiter, checked against a
// behavioural model of the round-robin write port.
module tb_rf_wr_arbiter;
    import rf_wr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_wr = '0;
    logic [31:0] wb_wd = '0;
    logic        wb_ready;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_wr = '0;
    logic [31:0] mc_wd = '0;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
`ifdef RF_WR_SCOREBOARD_EN
    logic        issue = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] busy;
    logic [31:0] busy_m;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: who won last tie-break, expected write-port contents.
    int          last_gnt;
    logic        ewe;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic [31:0] mdl_rf [32];
    logic [31:0] dut_rf [32];
    int          we_pulses;
    logic        wb_pend, mc_pend;
    logic [4:0]  wb_hold_a, mc_hold_a;
    logic [31:0] wb_hold_d, mc_hold_d;
    int          wb_wait, mc_wait;

    rf_wr_arbiter #(.NREQ(2)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
`ifdef RF_WR_SCOREBOARD_EN
        .issue_i    (issue),
        .issue_rd_i (issue_rd),
        .busy_o     (busy),
`endif
        .wb_valid_i (wb_valid),
        .wb_wr_i    (wb_wr),
        .wb_wd_i    (wb_wd),
        .wb_ready_o (wb_ready),
        .mc_valid_i (mc_valid),
        .mc_wr_i    (mc_wr),
        .mc_wd_i    (mc_wd),
        .mc_ready_o (mc_ready),
        .rf_we_o    (rf_we),
        .rf_wr_o    (rf_wr),
        .rf_wd_o    (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        last_gnt = 1;
        ewe = 1'b0;
        ewr = '0;
        ewd = '0;
        wb_pend = 1'b0;
        mc_pend = 1'b0;
        wb_wait = 0;
        mc_wait = 0;
`ifdef RF_WR_SCOREBOARD_EN
        busy_m = '0;
`endif
    endtask

    task automatic doReset();
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        mc_valid = 1'b0;
`ifdef RF_WR_SCOREBOARD_EN
        issue    = 1'b0;
`endif
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge: drives one cycle, checks ready at the
    // falling edge and the registered write port just after the next rising edge.
    task automatic applyStimulus(input logic wv, input logic [4:0] wa, input logic [31:0] wdat,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] mdat);
        int winner;
        if (wb_pend && !(wv && wa == wb_hold_a && wdat == wb_hold_d))
            $error("[TB] writeback request withdrawn while waiting");
        if (mc_pend && !(mv && ma == mc_hold_a && mdat == mc_hold_d))
            $error("[TB] multi-cycle request withdrawn while waiting");
        wb_valid = wv; wb_wr = wa; wb_wd = wdat;
        mc_valid = mv; mc_wr = ma; mc_wd = mdat;
        @(negedge clk);
        winner = -1;
        if (wv && mv) winner = (last_gnt == 0) ? 1 : 0;
        else if (wv)  winner = 0;
        else if (mv)  winner = 1;
        checkOutput("wb_ready", 32'(wb_ready), 32'(winner == 0));
        checkOutput("mc_ready", 32'(mc_ready), 32'(winner == 1));
        wb_wait = (wv && !wb_ready) ? wb_wait + 1 : 0;
        mc_wait = (mv && !mc_ready) ? mc_wait + 1 : 0;
        if (wv) checkOutput("wb_starve", 32'(wb_wait <= 1), 32'd1);
        if (mv) checkOutput("mc_starve", 32'(mc_wait <= 1), 32'd1);
        wb_pend = wv && !wb_ready; wb_hold_a = wa; wb_hold_d = wdat;
        mc_pend = mv && !mc_ready; mc_hold_a = ma; mc_hold_d = mdat;
        if (winner >= 0) begin
            last_gnt = winner;
            ewr = (winner == 1) ? ma : wa;
            ewd = (winner == 1) ? mdat : wdat;
            ewe = (ewr != 5'd0);
            if (ewe) mdl_rf[ewr] = ewd;
        end else begin
            ewe = 1'b0;
        end
`ifdef RF_WR_SCOREBOARD_EN
        if (winner >= 0) busy_m[ewr] = 1'b0;
        if (issue) busy_m[issue_rd] = 1'b1;
        busy_m[0] = 1'b0;
`endif
        @(posedge clk);
        #1;
        checkOutput("rf_we", 32'(rf_we), 32'(ewe));
        checkOutput("rf_wr", 32'(rf_wr), 32'(ewr));
        checkOutput("rf_wd", rf_wd, ewd);
`ifdef RF_WR_SCOREBOARD_EN
        checkOutput("busy", busy, busy_m);
`endif
        if (rf_we) begin
            we_pulses++;
            dut_rf[rf_wr] = rf_wd;
        end
    endtask

    initial begin
        logic        rwv, rmv;
        logic [4:0]  rwa, rma;
        logic [31:0] rwd, rmd;
        int          pulses0;
        int          order [4];

        for (int r = 0; r < 32; r++) begin
            mdl_rf[r] = '0;
            dut_rf[r] = '0;
        end
        we_pulses = 0;
        resetModel();

        // Reset state while reset is held from time zero.
        #1;
        checkOutput("reset_we", 32'(rf_we), 32'd0);
        checkOutput("reset_wr", 32'(rf_wr), 32'd0);
        checkOutput("reset_wd", rf_wd, 32'd0);
        checkOutput("idle_wb_ready", 32'(wb_ready), 32'd0);
`ifdef RF_WR_SCOREBOARD_EN
        checkOutput("reset_busy", busy, 32'd0);
`endif
        doReset();

        // Single writeback request.
        applyStimulus(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'h0);
        checkOutput("single_we", 32'(rf_we), 32'd1);
        checkOutput("single_wr", 32'(rf_wr), 32'd5);
        checkOutput("single_wd", rf_wd, 32'hA5A5_0001);

        // Contention from reset: wb, mc, wb, mc.
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 5'd3, 32'h0000_3333, 1'b1, 5'd7, 32'h0000_7777);
            order[c] = int'(rf_wr);
        end
        checkOutput("contend_0", 32'(order[0]), 32'd3);
        checkOutput("contend_1", 32'(order[1]), 32'd7);
        checkOutput("contend_2", 32'(order[2]), 32'd3);
        checkOutput("contend_3", 32'(order[3]), 32'd7);

        // Register 0 write is accepted but not strobed.
        doReset();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD_0000);
        checkOutput("r0_we", 32'(rf_we), 32'd0);

        // Same-address ordering.
        doReset();
        pulses0 = we_pulses;
        applyStimulus(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h22);
        checkOutput("order_pulses", 32'(we_pulses - pulses0), 32'd2);
        checkOutput("order_final", rf_wd, 32'h22);
        checkOutput("order_rf4", dut_rf[4], 32'h22);

        // Reset asserted in the middle of a writeback grant.
        doReset();
        applyStimulus(1'b1, 5'd6, 32'hBEEF_0006, 1'b0, 5'd0, 32'h0);
        wb_valid = 1'b1; wb_wr = 5'd8; wb_wd = 32'hBEEF_0008;
        #1;
        checkOutput("midrst_grant", 32'(wb_ready), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_we", 32'(rf_we), 32'd0);
        checkOutput("midrst_wr", 32'(rf_wr), 32'd0);
        checkOutput("midrst_wd", rf_wd, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_hold_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        reset_n  = 1'b1;
        resetModel();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_after_we", 32'(rf_we), 32'd0);
        end

`ifdef RF_WR_SCOREBOARD_EN
        doReset();
        issue = 1'b1; issue_rd = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        issue = 1'b0;
        checkOutput("sb_set9", 32'(busy[9]), 32'd1);
        applyStimulus(1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'h0);
        checkOutput("sb_clr9", 32'(busy[9]), 32'd0);
        issue = 1'b1; issue_rd = 5'd9;
        applyStimulus(1'b1, 5'd9, 32'h9998, 1'b0, 5'd0, 32'h0);
        checkOutput("sb_setwins9", 32'(busy[9]), 32'd1);
        issue_rd = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        issue = 1'b0;
        checkOutput("sb_r0", 32'(busy[0]), 32'd0);
`endif

        // Randomized traffic honouring the no-withdraw rule.
        doReset();
        for (int i = 0; i < 400; i++) begin
            if (wb_pend) begin
                rwv = 1'b1; rwa = wb_hold_a; rwd = wb_hold_d;
            end else begin
                rwv = ($urandom_range(0, 3) != 0);
                rwa = 5'($urandom_range(0, 31));
                rwd = $urandom;
            end
            if (mc_pend) begin
                rmv = 1'b1; rma = mc_hold_a; rmd = mc_hold_d;
            end else begin
                rmv = ($urandom_range(0, 2) != 0);
                rma = 5'($urandom_range(0, 31));
                rmd = $urandom;
            end
`ifdef RF_WR_SCOREBOARD_EN
            issue    = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 31));
`endif
            applyStimulus(rwv, rwa, rwd, rmv, rma, rmd);
        end

        for (int r = 0; r < 32; r++)
            checkOutput($sformatf("rf_contents_%0d", r), dut_rf[r], mdl_rf[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
